// File: rtl/pipe_pkg.sv
// Shared types for the valid/ready pipeline stage: the occupancy FSM encoding
// and a helper that maps a state onto the occupancy count it represents.
package pipe_pkg;

    localparam int PIPE_OCC_W = 2;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } pipe_state_t;

    function automatic logic [PIPE_OCC_W-1:0] occ_of(input pipe_state_t s);
        logic [PIPE_OCC_W-1:0] occ;
        case (s)
            EMPTY:   occ = 2'd0;
            BUSY:    occ = 2'd1;
            FULL:    occ = 2'd2;
            default: occ = 2'd0;
        endcase
        return occ;
    endfunction

endpackage

// File: rtl/pipe_entry_reg.sv
// One stage entry: a control field and a payload field with a load strobe and
// independent clears, so bubbles can drop control bits while keeping payload.
module pipe_entry_reg #(
    parameter int CTRL_W = 8,
    parameter int DATA_W = 128
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load,
    input  logic              i_clr_ctrl,
    input  logic              i_clr_data,
    input  logic [CTRL_W-1:0] i_ctrl,
    input  logic [DATA_W-1:0] i_data,
    output logic [CTRL_W-1:0] o_ctrl,
    output logic [DATA_W-1:0] o_data
);

    logic [CTRL_W-1:0] r_ctrl;
    logic [DATA_W-1:0] r_data;

    // Entry storage: reset zeroes everything, load wins over the clears.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_ctrl <= '0;
            r_data <= '0;
        end else if (i_load) begin
            r_ctrl <= i_ctrl;
            r_data <= i_data;
        end else begin
            if (i_clr_ctrl) begin
                r_ctrl <= '0;
            end
            if (i_clr_data) begin
                r_data <= '0;
            end
        end
    end

    assign o_ctrl = r_ctrl;
    assign o_data = r_data;

endmodule

// File: rtl/pipe_skid_stage.sv
// Pipeline stage register with valid/ready flow control, a second skid entry so
// in_ready never depends combinationally on out_ready, and a flush that empties it.
module pipe_skid_stage
    import pipe_pkg::*;
#(
    parameter int CTRL_W              = 8,
    parameter int DATA_W              = 128,
    parameter int CLEAR_DATA_ON_FLUSH = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [CTRL_W-1:0]     in_ctrl,
    input  logic [DATA_W-1:0]     in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [CTRL_W-1:0]     out_ctrl,
    output logic [DATA_W-1:0]     out_data,
    output logic [PIPE_OCC_W-1:0] occupancy
);

    pipe_state_t             r_state;
    pipe_state_t             w_next_state;
    logic                    r_in_ready;
    logic                    r_out_valid;
    logic [PIPE_OCC_W-1:0]   r_occupancy;

    logic                    w_main_load;
    logic                    w_main_from_skid;
    logic                    w_main_clr_ctrl;
    logic                    w_skid_load;
    logic                    w_skid_clr_ctrl;
    logic                    w_clr_data;

    logic [CTRL_W-1:0]       w_main_d_ctrl;
    logic [DATA_W-1:0]       w_main_d_data;
    logic [CTRL_W-1:0]       w_main_ctrl;
    logic [DATA_W-1:0]       w_main_data;
    logic [CTRL_W-1:0]       w_skid_ctrl;
    logic [DATA_W-1:0]       w_skid_data;

    // Next-state and entry-register strobes; flush overrides every transfer.
    always_comb begin
        w_next_state     = r_state;
        w_main_load      = 1'b0;
        w_main_from_skid = 1'b0;
        w_main_clr_ctrl  = 1'b0;
        w_skid_load      = 1'b0;
        w_skid_clr_ctrl  = 1'b0;
        w_clr_data       = 1'b0;
        if (flush) begin
            w_next_state    = EMPTY;
            w_main_clr_ctrl = 1'b1;
            w_skid_clr_ctrl = 1'b1;
            w_clr_data      = (CLEAR_DATA_ON_FLUSH != 0);
        end else begin
            case (r_state)
                EMPTY: begin
                    if (in_valid) begin
                        w_next_state = BUSY;
                        w_main_load  = 1'b1;
                    end else begin
                        w_main_clr_ctrl = 1'b1;
                    end
                end
                BUSY: begin
                    if (in_valid && out_ready) begin
                        w_main_load = 1'b1;
                    end else if (in_valid) begin
                        w_next_state = FULL;
                        w_skid_load  = 1'b1;
                    end else if (out_ready) begin
                        w_next_state    = EMPTY;
                        w_main_clr_ctrl = 1'b1;
                    end else begin
                        w_next_state = BUSY;
                    end
                end
                FULL: begin
                    // in_ready is low here, so in_valid is ignored entirely.
                    if (out_ready) begin
                        w_next_state     = BUSY;
                        w_main_load      = 1'b1;
                        w_main_from_skid = 1'b1;
                        w_skid_clr_ctrl  = 1'b1;
                    end else begin
                        w_next_state = FULL;
                    end
                end
                default: begin
                    w_next_state    = EMPTY;
                    w_main_clr_ctrl = 1'b1;
                    w_skid_clr_ctrl = 1'b1;
                end
            endcase
        end
    end

    assign w_main_d_ctrl = w_main_from_skid ? w_skid_ctrl : in_ctrl;
    assign w_main_d_data = w_main_from_skid ? w_skid_data : in_data;

    pipe_entry_reg #(
        .CTRL_W (CTRL_W),
        .DATA_W (DATA_W)
    ) u_main (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_main_load),
        .i_clr_ctrl (w_main_clr_ctrl),
        .i_clr_data (w_clr_data),
        .i_ctrl     (w_main_d_ctrl),
        .i_data     (w_main_d_data),
        .o_ctrl     (w_main_ctrl),
        .o_data     (w_main_data)
    );

    pipe_entry_reg #(
        .CTRL_W (CTRL_W),
        .DATA_W (DATA_W)
    ) u_skid (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_skid_load),
        .i_clr_ctrl (w_skid_clr_ctrl),
        .i_clr_data (w_clr_data),
        .i_ctrl     (in_ctrl),
        .i_data     (in_data),
        .o_ctrl     (w_skid_ctrl),
        .o_data     (w_skid_data)
    );

    // State register plus flow-control outputs registered from the next state.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= EMPTY;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_occupancy <= '0;
        end else begin
            r_state     <= w_next_state;
            r_in_ready  <= (w_next_state != FULL);
            r_out_valid <= (w_next_state != EMPTY);
            r_occupancy <= occ_of(w_next_state);
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign occupancy = r_occupancy;
    assign out_ctrl  = w_main_ctrl;
    assign out_data  = w_main_data;

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Bench for pipe_skid_stage: two instances (payload cleared / kept on flush)
// checked every cycle against a queue model, plus directed literal checks.
module tb_pipe_skid_stage;

    localparam int CW = 8;
    localparam int DW = 128;

    logic          clk;
    logic          rst;
    logic          flush;
    logic          in_valid;
    logic          out_ready;
    logic [CW-1:0] in_ctrl;
    logic [DW-1:0] in_data;

    logic          rdy1, vld1, rdy0, vld0;
    logic [CW-1:0] ctrl1, ctrl0;
    logic [DW-1:0] data1, data0;
    logic [1:0]    occ1, occ0;

    pipe_skid_stage #(.CTRL_W(CW), .DATA_W(DW), .CLEAR_DATA_ON_FLUSH(1)) u_clr (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(rdy1), .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(vld1), .out_ready(out_ready), .out_ctrl(ctrl1), .out_data(data1),
        .occupancy(occ1)
    );

    pipe_skid_stage #(.CTRL_W(CW), .DATA_W(DW), .CLEAR_DATA_ON_FLUSH(0)) u_keep (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(rdy0), .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(vld0), .out_ready(out_ready), .out_ctrl(ctrl0), .out_data(data0),
        .occupancy(occ0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    bit check_en = 1'b0;

    typedef struct {
        logic [CW-1:0] c;
        logic [DW-1:0] d;
    } ent_t;

    ent_t          mq[$];
    logic [DW-1:0] hold_clr;
    logic [DW-1:0] hold_keep;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Model: a FIFO of at most two entries; the output shows its head, and
    // when empty the payload shows whatever the head last was.
    always @(posedge clk) begin
        int   sz;
        ent_t e;
        sz = mq.size();
        if (!rst) begin
            mq.delete();
            hold_clr  = '0;
            hold_keep = '0;
        end else if (flush) begin
            mq.delete();
            hold_clr = '0;
        end else begin
            if (sz > 0 && out_ready) void'(mq.pop_front());
            if (in_valid && sz < 2) begin
                e.c = in_ctrl;
                e.d = in_data;
                mq.push_back(e);
            end
            if (mq.size() > 0) begin
                hold_clr  = mq[0].d;
                hold_keep = mq[0].d;
            end
        end
    end

    task automatic cmp_dut(input string tag, input logic rdy, input logic vld,
                           input logic [CW-1:0] c, input logic [DW-1:0] d,
                           input logic [1:0] occ, input logic [DW-1:0] hold);
        logic [CW-1:0] ec;
        logic [DW-1:0] ed;
        int            sz;
        sz = mq.size();
        if (sz > 0) begin
            ec = mq[0].c;
            ed = mq[0].d;
        end else begin
            ec = '0;
            ed = hold;
        end
        chk({tag, "_in_ready"},  DW'(rdy), DW'(sz < 2));
        chk({tag, "_out_valid"}, DW'(vld), DW'(sz > 0));
        chk({tag, "_out_ctrl"},  DW'(c),   DW'(ec));
        chk({tag, "_out_data"},  d,        ed);
        chk({tag, "_occupancy"}, DW'(occ), DW'(sz));
    endtask

    // Per-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (check_en) begin
            cmp_dut("clr",  rdy1, vld1, ctrl1, data1, occ1, hold_clr);
            cmp_dut("keep", rdy0, vld0, ctrl0, data0, occ0, hold_keep);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst = 1'b0; flush = 1'b0; in_valid = 1'b1; in_ctrl = 8'h11;
        in_data = 128'h77; out_ready = 1'b0;

        // Reset held two cycles with in_valid asserted
        cyc();
        check_en = 1'b1;
        cyc();
        chk("rst_out_valid", DW'(vld1),  DW'(1'b0));
        chk("rst_out_ctrl",  DW'(ctrl1), DW'(8'h00));
        chk("rst_out_data",  data1,      128'h0);
        chk("rst_occupancy", DW'(occ1),  DW'(2'd0));
        rst = 1'b1; in_valid = 1'b0;
        chk("rst_in_ready_first", DW'(rdy1), DW'(1'b1));

        // Streaming 1..8 with out_ready held high
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            in_valid = 1'b1; in_ctrl = 8'hA5; in_data = DW'(i);
            cyc();
            chk("stream_data", data1, DW'(i));
            chk("stream_ctrl", DW'(ctrl1), DW'(8'hA5));
            chk("stream_occ",  DW'(occ1), DW'(2'd1));
        end
        in_valid = 1'b0;
        cyc();
        chk("drain_valid", DW'(vld1), DW'(1'b0));
        chk("drain_ctrl",  DW'(ctrl1), DW'(8'h00));
        chk("drain_data",  data1, 128'd8);

        // Stall into the skid and drain in order
        in_valid = 1'b1; in_ctrl = 8'h3C; in_data = 128'hA;
        cyc();
        in_data = 128'hB; out_ready = 1'b0;
        cyc();
        chk("skid_occ",   DW'(occ1), DW'(2'd2));
        chk("skid_ready", DW'(rdy1), DW'(1'b0));
        chk("skid_hold",  data1, 128'hA);
        in_valid = 1'b0; out_ready = 1'b1;
        cyc();
        chk("skid_second", data1, 128'hB);
        chk("skid_occ1",   DW'(occ1), DW'(2'd1));
        cyc();
        chk("skid_empty",  DW'(vld1), DW'(1'b0));

        // Flush while FULL with C offered on the input
        out_ready = 1'b0; in_valid = 1'b1; in_ctrl = 8'h5A; in_data = 128'hD1;
        cyc();
        in_data = 128'hD2;
        cyc();
        flush = 1'b1; in_data = 128'hC;
        cyc();
        chk("flush_valid",     DW'(vld1),  DW'(1'b0));
        chk("flush_ctrl",      DW'(ctrl1), DW'(8'h00));
        chk("flush_occ",       DW'(occ1),  DW'(2'd0));
        chk("flush_data_clr",  data1, 128'h0);
        chk("flush_data_keep", data0, 128'hD1);
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        cyc();
        chk("flush_no_c", DW'(vld1), DW'(1'b0));

        // Flush held three cycles keeps the stage empty and ready
        flush = 1'b1; in_valid = 1'b1; in_data = 128'hF0;
        for (int k = 0; k < 3; k++) begin
            cyc();
            chk("flush_hold_ready", DW'(rdy1), DW'(1'b1));
            chk("flush_hold_occ",   DW'(occ1), DW'(2'd0));
        end
        flush = 1'b0; in_valid = 1'b0;

        // Bubble clears control but keeps payload
        in_valid = 1'b1; in_ctrl = 8'hFF; in_data = 128'h55;
        cyc();
        chk("bubble_load_ctrl", DW'(ctrl1), DW'(8'hFF));
        in_valid = 1'b0;
        cyc();
        chk("bubble_ctrl",      DW'(ctrl1), DW'(8'h00));
        chk("bubble_data",      data1, 128'h55);
        chk("bubble_data_keep", data0, 128'h55);

        // Reset together with flush while FULL
        out_ready = 1'b0; in_valid = 1'b1; in_ctrl = 8'h81; in_data = 128'hE1;
        cyc();
        in_data = 128'hE2;
        cyc();
        chk("mid_full", DW'(occ1), DW'(2'd2));
        rst = 1'b0; flush = 1'b1;
        cyc();
        chk("mid_valid",     DW'(vld0), DW'(1'b0));
        chk("mid_ctrl",      DW'(ctrl0), DW'(8'h00));
        chk("mid_data_keep", data0, 128'h0);
        chk("mid_occ",       DW'(occ0), DW'(2'd0));
        chk("mid_ready",     DW'(rdy0), DW'(1'b1));
        rst = 1'b1; flush = 1'b0;

        // Random traffic against the model
        for (int n = 0; n < 300; n++) begin
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
            flush     = ($urandom_range(0, 15) == 0);
            in_ctrl   = 8'($urandom);
            in_data   = {$urandom, $urandom, $urandom, $urandom};
            cyc();
        end

        @(negedge clk);
        #1;
        check_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
